// File: rtl/freq_detector_period_avg.sv
// rtl/freq_detector_period_avg.sv - period detector with averaged history, stability window and no-signal timeout
// Optional high-time (duty) measurement is enabled by defining FREQ_DET_DUTY_EN.
module freq_detector_period_avg #(
  parameter int COUNTER_WIDTH = 18,
  parameter int DEPTH_LOG2    = 2,
  parameter int THRESH_SHIFT  = 5,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     signal_in,
  input  logic                     edge_sel,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic                     period_valid,
  output logic                     stable,
  output logic                     no_signal,
  output logic [COUNTER_WIDTH-1:0] high_time
);

  localparam int D   = 1 << DEPTH_LOG2;
  localparam int SW  = COUNTER_WIDTH + DEPTH_LOG2;
  localparam int FW  = DEPTH_LOG2 + 1;
  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [FW-1:0]            FILL_FULL = FW'(D);
  localparam logic [DEPTH_LOG2-1:0]    IDX_LAST  = DEPTH_LOG2'(D - 1);
  localparam logic [SCW-1:0]           SC_MAX    = SCW'(STABLE_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_AVG, S_CHECK, S_DONE} state_t;

  state_t                   state_q;
  logic                     sig_q, prev_q, sel_q;
  logic                     discard_q, fast_q, no_signal_q;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d, cap_q;
  logic [COUNTER_WIDTH-1:0] hist_q [D];
  logic [SW-1:0]            sum_q;
  logic [FW-1:0]            fill_q;
  logic [COUNTER_WIDTH-1:0] avg_q, lo_q, period_q;
  logic [COUNTER_WIDTH:0]   hi_q;
  logic [DEPTH_LOG2-1:0]    idx_q;
  logic                     in_range_q, valid_q, stable_q;
  logic [SCW-1:0]           stable_cnt_q, stable_cnt_d;

  logic                     edge_w, sel_chg_w, sat_w, h_ok_w, range_fin_w;
  logic [COUNTER_WIDTH-1:0] avg_w, thr_w, h_cur_w;

  assign edge_w      = edge_sel ? (prev_q & ~sig_q) : (sig_q & ~prev_q);
  assign sel_chg_w   = edge_sel ^ sel_q;
  assign sat_w       = (cnt_q == CNT_MAX) && !edge_w;
  assign avg_w       = sum_q[SW-1:DEPTH_LOG2];
  assign thr_w       = avg_w >> THRESH_SHIFT;
  assign h_cur_w     = hist_q[idx_q];
  assign h_ok_w      = (h_cur_w >= lo_q) && ({1'b0, h_cur_w} <= hi_q);
  assign range_fin_w = in_range_q & h_ok_w;

  always_comb begin
    cnt_d = cnt_q;
    if (edge_w)
      cnt_d = COUNTER_WIDTH'(1);
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  // A too-fast edge seen since the last DONE poisons the stability run.
  always_comb begin
    stable_cnt_d = '0;
    if (range_fin_w && !fast_q)
      stable_cnt_d = (stable_cnt_q == SC_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
  end

`ifdef FREQ_DET_DUTY_EN
  logic [COUNTER_WIDTH-1:0] hcnt_q, hcnt_d, hcap_q, high_q;
  logic [COUNTER_WIDTH-1:0] hhist_q [D];
  logic [SW-1:0]            hsum_q;

  always_comb begin
    hcnt_d = hcnt_q;
    if (edge_w)
      hcnt_d = COUNTER_WIDTH'(sig_q);
    else if (sig_q && hcnt_q != CNT_MAX)
      hcnt_d = hcnt_q + 1'b1;
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

  assign period       = period_q;
  assign period_valid = valid_q;
  assign stable       = stable_q;
  assign no_signal    = no_signal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sig_q        <= 1'b0;
      prev_q       <= 1'b0;
      sel_q        <= 1'b0;
      discard_q    <= 1'b1;
      fast_q       <= 1'b0;
      no_signal_q  <= 1'b0;
      cnt_q        <= '0;
      cap_q        <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
      avg_q        <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      idx_q        <= '0;
      in_range_q   <= 1'b0;
      valid_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_cnt_q <= '0;
      period_q     <= '0;
      for (int i = 0; i < D; i++) hist_q[i] <= '0;
`ifdef FREQ_DET_DUTY_EN
      hcnt_q <= '0;
      hcap_q <= '0;
      high_q <= '0;
      hsum_q <= '0;
      for (int i = 0; i < D; i++) hhist_q[i] <= '0;
`endif
    end else begin
      sig_q   <= signal_in;
      prev_q  <= sig_q;
      sel_q   <= edge_sel;
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
`ifdef FREQ_DET_DUTY_EN
      hcnt_q  <= hcnt_d;
`endif

      case (state_q)
        S_IDLE: ;
        S_UPDATE: begin
          for (int i = 0; i < D - 1; i++) hist_q[i] <= hist_q[i+1];
          hist_q[D-1] <= cap_q;
          sum_q       <= sum_q + SW'(cap_q) - SW'(hist_q[0]);
`ifdef FREQ_DET_DUTY_EN
          for (int i = 0; i < D - 1; i++) hhist_q[i] <= hhist_q[i+1];
          hhist_q[D-1] <= hcap_q;
          hsum_q       <= hsum_q + SW'(hcap_q) - SW'(hhist_q[0]);
`endif
          if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
          state_q <= S_AVG;
        end
        S_AVG: begin
          avg_q      <= avg_w;
          lo_q       <= avg_w - thr_w;
          hi_q       <= {1'b0, avg_w} + {1'b0, thr_w};
          idx_q      <= '0;
          in_range_q <= 1'b1;
          state_q    <= S_CHECK;
        end
        S_CHECK: begin
          in_range_q <= range_fin_w;
          idx_q      <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            if (fill_q == FILL_FULL) begin
              period_q     <= avg_q;
              valid_q      <= 1'b1;
              stable_cnt_q <= stable_cnt_d;
              stable_q     <= (stable_cnt_d == SC_MAX);
              fast_q       <= 1'b0;
`ifdef FREQ_DET_DUTY_EN
              high_q       <= hsum_q[SW-1:DEPTH_LOG2];
`endif
              state_q      <= S_DONE;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (edge_w) begin
        no_signal_q <= 1'b0;
        if (discard_q) begin
          discard_q <= 1'b0;
        end else if (state_q != S_IDLE) begin
          fast_q <= 1'b1;
        end else begin
          cap_q   <= cnt_q;
`ifdef FREQ_DET_DUTY_EN
          hcap_q  <= hcnt_q;
`endif
          state_q <= S_UPDATE;
        end
      end

      // Switching edge polarity invalidates the history; the next edge is a half-period.
      if (sel_chg_w) begin
        discard_q <= 1'b1;
        sum_q     <= '0;
        fill_q    <= '0;
        state_q   <= S_IDLE;
        for (int i = 0; i < D; i++) hist_q[i] <= '0;
`ifdef FREQ_DET_DUTY_EN
        hsum_q <= '0;
        for (int i = 0; i < D; i++) hhist_q[i] <= '0;
`endif
      end

      if (sat_w) begin
        no_signal_q  <= 1'b1;
        discard_q    <= 1'b1;
        sum_q        <= '0;
        fill_q       <= '0;
        stable_cnt_q <= '0;
        stable_q     <= 1'b0;
        state_q      <= S_IDLE;
        for (int i = 0; i < D; i++) hist_q[i] <= '0;
`ifdef FREQ_DET_DUTY_EN
        hsum_q <= '0;
        for (int i = 0; i < D; i++) hhist_q[i] <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_freq_detector_period_avg.sv
// tb/tb_freq_detector_period_avg.sv - scoreboard bench for freq_detector_period_avg
// Event-level reference model predicts each period_valid pulse; a monitor pops and compares.
module tb_freq_detector_period_avg;

  localparam int CW = 13;
  localparam int DL = 2;
  localparam int D  = 1 << DL;
  localparam int TS = 5;
  localparam int SC = 4;
`ifdef FREQ_DET_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          signal_in;
  logic          edge_sel;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          stable;
  logic          no_signal;
  logic [CW-1:0] high_time;

  freq_detector_period_avg #(
    .COUNTER_WIDTH(CW), .DEPTH_LOG2(DL), .THRESH_SHIFT(TS), .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .edge_sel(edge_sel),
    .period(period), .period_valid(period_valid), .stable(stable),
    .no_signal(no_signal), .high_time(high_time)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int period;
    int stab;
    int high;
    int at;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  int m_hist[D];
  int m_hhist[D];
  int m_fill, m_scnt, m_last_period;
  bit m_disc, m_fast, last_pulsed, cur_sig;
  int t_prev, t_cap, t_rise, hi_acc;

  task automatic model_clear_hist();
    for (int i = 0; i < D; i++) begin
      m_hist[i]  = 0;
      m_hhist[i] = 0;
    end
    m_fill = 0;
    m_disc = 1'b1;
  endtask

  task automatic model_edge(input int k);
    int   c, hc, sum, hsum, avg, thr, lo, hi;
    bit   inr;
    exp_t e;
    c      = k - t_prev;
    hc     = hi_acc;
    t_prev = k;
    hi_acc = 0;
    if (m_disc) begin
      m_disc = 1'b0;
    end else if (k - t_cap < D + 4) begin
      // Early enough to land before the in-flight DONE: that pulse loses stability.
      if ((k - t_cap <= D + 1) && last_pulsed) begin
        sb_q[sb_q.size()-1].stab = 0;
        m_scnt = 0;
      end else begin
        m_fast = 1'b1;
      end
    end else begin
      for (int i = 0; i < D - 1; i++) begin
        m_hist[i]  = m_hist[i+1];
        m_hhist[i] = m_hhist[i+1];
      end
      m_hist[D-1]  = c;
      m_hhist[D-1] = hc;
      t_cap        = k;
      if (m_fill < D) m_fill++;
      last_pulsed = (m_fill == D);
      if (last_pulsed) begin
        sum  = 0;
        hsum = 0;
        for (int i = 0; i < D; i++) begin
          sum  += m_hist[i];
          hsum += m_hhist[i];
        end
        avg = sum >> DL;
        thr = avg >> TS;
        lo  = avg - thr;
        hi  = avg + thr;
        inr = 1'b1;
        for (int i = 0; i < D; i++)
          if (m_hist[i] < lo || m_hist[i] > hi) inr = 1'b0;
        if (!inr || m_fast) m_scnt = 0;
        else if (m_scnt < SC) m_scnt++;
        m_fast   = 1'b0;
        e.period = avg;
        e.stab   = (m_scnt == SC) ? 1 : 0;
        e.high   = DUTY ? (hsum >> DL) : 0;
        e.at     = k + D + 4;
        sb_q.push_back(e);
        m_last_period = avg;
      end
    end
  endtask

  task automatic set_sig(input bit v);
    int k;
    k = cyc;
    signal_in = v;
    if (v && !cur_sig) t_rise = k;
    if (!v && cur_sig) hi_acc += k - t_rise;
    if ((edge_sel == 1'b0 && v && !cur_sig) || (edge_sel == 1'b1 && !v && cur_sig))
      model_edge(k);
    cur_sig = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int p, input int h, input int n);
    repeat (n) begin
      set_sig(1'b1);
      idle(h);
      set_sig(1'b0);
      idle(p - h);
    end
  endtask

  task automatic flip_sel();
    edge_sel = ~edge_sel;
    model_clear_hist();
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && period_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", period_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("period", period, mon_e.period);
        check("stable_at_pulse", stable, mon_e.stab);
        check("high_time", high_time, mon_e.high);
        check("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    signal_in = 1'b0;
    edge_sel  = 1'b0;
    cur_sig   = 1'b0;
    m_scnt    = 0;
    m_fast    = 1'b0;
    m_last_period = 0;
    last_pulsed = 1'b0;
    t_prev    = 0;
    t_cap     = -1000000;
    t_rise    = 0;
    hi_acc    = 0;
    model_clear_hist();

    idle(3);
    check("rst_period", period, 0);
    check("rst_valid", period_valid, 0);
    check("rst_stable", stable, 0);
    check("rst_no_signal", no_signal, 0);
    check("rst_high_time", high_time, 0);
    rst = 1'b0;
    idle(2);

    // Steady 2000-cycle square: first pulse at edge 5, stable at 4th pulse.
    wave(2000, 1000, 8);
    check("s1_stable", stable, 1);
    check("s1_drained", sb_q.size(), 0);

    // Alternating 2000/2100 stays inside the window, 2200 breaks it.
    repeat (4) begin
      wave(2100, 1050, 1);
      wave(2000, 1000, 1);
    end
    check("s2_alt_stable", stable, 1);
    wave(2200, 1100, 2);
    check("s2_jump_unstable", stable, 0);
    check("s2_drained", sb_q.size(), 0);

    // No edges long enough to saturate the counter.
    idle(8300);
    check("s3_no_signal", no_signal, 1);
    check("s3_stable_cleared", stable, 0);
    check("s3_period_held", period, m_last_period);
    m_scnt = 0;
    model_clear_hist();
    wave(2000, 1000, 5);
    check("s3_no_signal_cleared", no_signal, 0);
    check("s3_drained", sb_q.size(), 0);

    // Switch to falling edges in the middle of a high phase.
    set_sig(1'b1);
    idle(500);
    flip_sel();
    idle(500);
    set_sig(1'b0);
    idle(1000);
    wave(2000, 1000, 4);
    check("s4_period", period, 2000);
    check("s4_drained", sb_q.size(), 0);

    // Back to rising edges, then a burst faster than the FSM can accept.
    flip_sel();
    idle(20);
    wave(5, 2, 6);
    check("s5_fast_no_pulse", sb_q.size(), 0);

    // 25% duty at 4000 cycles recovers the average.
    wave(4000, 1000, 4);
    set_sig(1'b1);
    idle(20);
    check("s6_period", period, 4000);
    check("s6_high_time", high_time, DUTY ? 1000 : 0);
    check("final_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
